// File: rtl/audio_dac_serializer_if.sv
// Producer-side sample bus of the DAC serializer: stereo sample pair, push request,
// FIFO flush, and the space/level indications returned by the serializer.
interface audio_dac_serializer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4
);
    logic [DATA_WIDTH-1:0]         left_channel_audio_out;
    logic [DATA_WIDTH-1:0]         right_channel_audio_out;
    logic                          write_audio_out;
    logic                          clear_audio_out_memory;
    logic                          audio_out_allowed;
    logic [$clog2(FIFO_DEPTH):0]   fifo_level;

    modport master (
        output left_channel_audio_out,
        output right_channel_audio_out,
        output write_audio_out,
        output clear_audio_out_memory,
        input  audio_out_allowed,
        input  fifo_level
    );

    modport slave (
        input  left_channel_audio_out,
        input  right_channel_audio_out,
        input  write_audio_out,
        input  clear_audio_out_memory,
        output audio_out_allowed,
        output fifo_level
    );
endinterface

// File: rtl/audio_dac_serializer.sv
// I2S master DAC serializer: buffers sample pairs in a small FIFO and shifts them out MSB-first.
// Push lands next cycle; producer is throttled by audio_out_allowed; the codec side never stalls.
module audio_dac_serializer #(
    parameter int DATA_WIDTH = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int BCLK_HALF  = 8
) (
    input  logic                  CLOCK_50,
    input  logic                  reset,
    audio_dac_serializer_if.slave aud,
    output logic                  underflow,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT
);
    localparam int PW   = $clog2(FIFO_DEPTH);
    localparam int LW   = PW + 1;
    localparam int BW   = $clog2(2 * DATA_WIDTH);
    localparam int IW   = $clog2(DATA_WIDTH);
    localparam int CW   = $clog2(BCLK_HALF);

    logic [DATA_WIDTH-1:0] mem_l [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]         level_q, level_d;
    logic [CW-1:0]         div_cnt_q, div_cnt_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] left_q, left_d, right_q, right_d;
    logic                  bclk_q, bclk_d, lrck_q, lrck_d, dat_q, dat_d;
    logic                  uf_q, uf_d, last_bit_q, last_bit_d;

    logic                  full, empty, push, pop, tick, fe, frame_start, ch;
    logic [BW-1:0]         n, slot_i;
    logic [IW-1:0]         bit_idx;

    always_comb begin
        full        = (level_q == LW'(FIFO_DEPTH));
        empty       = (level_q == '0);
        push        = aud.write_audio_out && !full && !aud.clear_audio_out_memory;
        tick        = (div_cnt_q == CW'(BCLK_HALF - 1));
        fe          = tick && bclk_q;
        n           = (bit_cnt_q == BW'(2 * DATA_WIDTH - 1)) ? '0 : bit_cnt_q + 1'b1;
        ch          = (n >= BW'(DATA_WIDTH));
        slot_i      = ch ? n - BW'(DATA_WIDTH) : n;
        bit_idx     = IW'(BW'(DATA_WIDTH) - slot_i);
        frame_start = fe && (n == '0);
        pop         = frame_start && !empty;
    end

    // FIFO bookkeeping; a flush wins over any same-cycle push or pop.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (aud.clear_audio_out_memory) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end
    end

    always_comb begin
        div_cnt_d  = tick ? '0 : div_cnt_q + 1'b1;
        bclk_d     = tick ? ~bclk_q : bclk_q;
        bit_cnt_d  = bit_cnt_q;
        lrck_d     = lrck_q;
        dat_d      = dat_q;
        left_d     = left_q;
        right_d    = right_q;
        last_bit_d = last_bit_q;
        uf_d       = frame_start && empty;
        if (fe) begin
            bit_cnt_d = n;
            lrck_d    = ch;
            if (n == '0) begin
                // Right-word LSB must be captured before the pop replaces the holding words.
                last_bit_d = right_q[0];
                left_d     = empty ? '0 : mem_l[rd_ptr_q];
                right_d    = empty ? '0 : mem_r[rd_ptr_q];
            end else if (n == BW'(DATA_WIDTH)) begin
                last_bit_d = left_q[0];
            end
            if (slot_i == '0) dat_d = last_bit_d;
            else              dat_d = ch ? right_q[bit_idx] : left_q[bit_idx];
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (push) begin
            mem_l[wr_ptr_q] <= aud.left_channel_audio_out;
            mem_r[wr_ptr_q] <= aud.right_channel_audio_out;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            div_cnt_q  <= '0;
            bit_cnt_q  <= BW'(2 * DATA_WIDTH - 1);
            left_q     <= '0;
            right_q    <= '0;
            bclk_q     <= 1'b0;
            lrck_q     <= 1'b1;
            dat_q      <= 1'b0;
            uf_q       <= 1'b0;
            last_bit_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            div_cnt_q  <= div_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            left_q     <= left_d;
            right_q    <= right_d;
            bclk_q     <= bclk_d;
            lrck_q     <= lrck_d;
            dat_q      <= dat_d;
            uf_q       <= uf_d;
            last_bit_q <= last_bit_d;
        end
    end

    assign aud.fifo_level        = level_q;
    assign aud.audio_out_allowed = !full;
    assign underflow             = uf_q;
    assign AUD_BCLK              = bclk_q;
    assign AUD_DACLRCK           = lrck_q;
    assign AUD_DACDAT            = dat_q;
endmodule

// File: tb/tb_audio_dac_serializer.sv
// Bench for audio_dac_serializer: pushed pairs go to a scoreboard queue that is popped at each
// observed frame start and compared bit by bit against the serial stream.
module tb_audio_dac_serializer;
    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam int BH    = 8;
    localparam int FRAME = 2 * DW * 2 * BH;

    typedef struct packed { logic [DW-1:0] l; logic [DW-1:0] r; } pair_t;
    typedef struct {
        logic [DW-1:0] l;
        logic [DW-1:0] r;
        logic          wr;
        int            exp_level;
        logic          exp_allowed;
    } vec_t;

    logic CLOCK_50 = 1'b0;
    logic reset    = 1'b1;
    logic underflow, AUD_BCLK, AUD_DACLRCK, AUD_DACDAT;

    audio_dac_serializer_if #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) aud ();

    audio_dac_serializer #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .BCLK_HALF(BH)) dut (
        .CLOCK_50    (CLOCK_50),
        .reset       (reset),
        .aud         (aud),
        .underflow   (underflow),
        .AUD_BCLK    (AUD_BCLK),
        .AUD_DACLRCK (AUD_DACLRCK),
        .AUD_DACDAT  (AUD_DACDAT)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    int    checks = 0;
    int    errors = 0;
    pair_t sb_q[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic timeout_fail(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", nm);
    endtask

    // Producer inputs as seen by the DUT at each rising edge.
    logic  pend_wr = 1'b0, pend_clr = 1'b0;
    pair_t pend_pair = '0;
    always @(posedge CLOCK_50) begin
        pend_wr   = aud.write_audio_out;
        pend_clr  = aud.clear_audio_out_memory;
        pend_pair = {aud.left_channel_audio_out, aud.right_channel_audio_out};
    end

    int    n_mon = 2 * DW - 1, since_fe = 0, uf_seen = 0, m_i, m_ch, m_pre;
    logic  bclk_prev = 1'b0, exp_dat = 1'b0, exp_lrck = 1'b1, prev_r0 = 1'b0, m_fe, m_uf;
    pair_t cur = '0;

    always @(negedge CLOCK_50) begin
        if (reset) begin
            sb_q.delete();
            n_mon = 2 * DW - 1; since_fe = 0; cur = '0; exp_dat = 1'b0; exp_lrck = 1'b1;
            chk("rst_bclk", AUD_BCLK, 0);
            chk("rst_lrck", AUD_DACLRCK, 1);
            chk("rst_dat", AUD_DACDAT, 0);
            chk("rst_level", aud.fifo_level, 0);
            chk("rst_allowed", aud.audio_out_allowed, 1);
            chk("rst_underflow", underflow, 0);
        end else begin
            m_fe  = bclk_prev && !AUD_BCLK;
            m_uf  = 1'b0;
            m_pre = sb_q.size();
            if (m_fe) begin
                chk("bclk_period", since_fe, 2 * BH - 1);
                since_fe = 0;
                n_mon = (n_mon + 1) % (2 * DW);
                m_ch  = n_mon / DW;
                m_i   = n_mon % DW;
                if (n_mon == 0) begin
                    prev_r0 = cur.r[0];
                    if (sb_q.size() == 0) begin cur = '0; m_uf = 1'b1; end
                    else cur = sb_q.pop_front();
                end
                if (m_i == 0) exp_dat = (m_ch == 0) ? prev_r0 : cur.l[0];
                else          exp_dat = (m_ch == 0) ? cur.l[DW-m_i] : cur.r[DW-m_i];
                exp_lrck = (m_ch != 0);
            end else begin
                since_fe++;
            end
            if (pend_clr) sb_q.delete();
            else if (pend_wr && m_pre < DEPTH) sb_q.push_back(pend_pair);
            chk("underflow", underflow, m_uf);
            if (underflow) uf_seen++;
            chk("lrck", AUD_DACLRCK, exp_lrck);
            chk("dacdat", AUD_DACDAT, exp_dat);
            chk("fifo_level", aud.fifo_level, sb_q.size());
            chk("allowed", aud.audio_out_allowed, sb_q.size() != DEPTH);
        end
        bclk_prev = AUD_BCLK;
    end

    task automatic pulse_reset();
        @(negedge CLOCK_50); #1 reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        #1 reset = 1'b0;
    endtask

    task automatic release_check_fe();
        logic prev = 1'b0;
        bit   found = 0;
        @(negedge CLOCK_50); #1 reset = 1'b0;
        for (int c = 1; c <= 40 && !found; c++) begin
            @(negedge CLOCK_50); #1;
            if (prev && !AUD_BCLK) begin
                found = 1;
                chk("first_fe_cycle", c, 16);
                chk("first_fe_lrck", AUD_DACLRCK, 0);
            end
            prev = AUD_BCLK;
        end
        if (!found) timeout_fail("first_fe");
    endtask

    task automatic drive(input logic wr, input logic clr, input logic [DW-1:0] l, input logic [DW-1:0] r);
        aud.write_audio_out         = wr;
        aud.clear_audio_out_memory  = clr;
        aud.left_channel_audio_out  = l;
        aud.right_channel_audio_out = r;
    endtask

    vec_t vecs[5];
    int   base, acc;
    bit   ok;

    initial begin
        vecs[0] = '{32'h8000_0001, 32'h7FFF_FFFE, 1'b1, 1, 1'b1};
        vecs[1] = '{32'hA5A5_5A5A, 32'h0F0F_F0F0, 1'b1, 2, 1'b1};
        vecs[2] = '{32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 3, 1'b1};
        vecs[3] = '{32'h1234_5678, 32'h9ABC_DEF1, 1'b1, 4, 1'b0};
        vecs[4] = '{32'hDEAD_BEEF, 32'hCAFE_F00D, 1'b1, 4, 1'b0};
        drive(1'b0, 1'b0, '0, '0);

        // Idle after reset: silent frames, one underflow per frame start.
        repeat (2) @(negedge CLOCK_50);
        base = uf_seen;
        release_check_fe();
        repeat (FRAME + 8) @(negedge CLOCK_50);
        #1 chk("idle_underflows", uf_seen - base, 2);

        // Table pushes before the first frame, including one write while full.
        pulse_reset();
        foreach (vecs[k]) begin
            drive(vecs[k].wr, 1'b0, vecs[k].l, vecs[k].r);
            @(negedge CLOCK_50); #1;
            chk($sformatf("vec%0d_level", k), aud.fifo_level, vecs[k].exp_level);
            chk($sformatf("vec%0d_allowed", k), aud.audio_out_allowed, vecs[k].exp_allowed);
        end
        drive(1'b0, 1'b0, '0, '0);
        repeat (5 * FRAME) @(negedge CLOCK_50);

        // Write held high: fill to depth, then one accept per frame-start pop.
        pulse_reset();
        acc = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            drive(1'b1, 1'b0, $urandom, $urandom);
            if (aud.audio_out_allowed) acc++;
            @(negedge CLOCK_50); #1;
        end
        drive(1'b0, 1'b0, '0, '0);
        chk("hold_accepts", acc, DEPTH + 3);
        chk("hold_level", aud.fifo_level, DEPTH);
        chk("hold_allowed", aud.audio_out_allowed, 0);

        // One entry left, push lands on the frame-start pop edge.
        ok = 0;
        for (int c = 0; c < 4 * FRAME; c++) begin
            if (sb_q.size() == 1) begin ok = 1; break; end
            @(negedge CLOCK_50); #1;
        end
        if (!ok) timeout_fail("drain_to_one");
        ok = 0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            if (n_mon == 2 * DW - 1 && since_fe == 2 * BH - 1) begin ok = 1; break; end
            @(negedge CLOCK_50); #1;
        end
        if (!ok) timeout_fail("frame_start_wait");
        drive(1'b1, 1'b0, 32'h1357_9BDF, 32'h2468_ACE0);
        @(negedge CLOCK_50); #1;
        drive(1'b0, 1'b0, '0, '0);
        chk("pushpop_level", aud.fifo_level, 1);
        chk("pushpop_no_uf", underflow, 0);

        // Flush with a same-cycle write while three entries are held.
        drive(1'b1, 1'b0, 32'h0000_00FF, 32'hFF00_0000);
        @(negedge CLOCK_50); #1;
        drive(1'b1, 1'b0, 32'h5555_AAAA, 32'hAAAA_5555);
        @(negedge CLOCK_50); #1;
        chk("flush_pre_level", aud.fifo_level, 3);
        drive(1'b1, 1'b1, 32'h0BAD_0BAD, 32'h0BAD_0BAD);
        @(negedge CLOCK_50); #1;
        drive(1'b0, 1'b0, '0, '0);
        chk("flush_level", aud.fifo_level, 0);
        base = uf_seen;
        repeat (FRAME) @(negedge CLOCK_50);
        #1 chk("flush_underflow", uf_seen - base, 1);

        // Reset asserted mid-frame at bit 40 with BCLK high and data in flight.
        drive(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        repeat (2) @(negedge CLOCK_50);
        #1 drive(1'b0, 1'b0, '0, '0);
        ok = 0;
        for (int c = 0; c < 3 * FRAME; c++) begin
            if (n_mon == 40 && since_fe == 10 && sb_q.size() == 1) begin ok = 1; break; end
            @(negedge CLOCK_50); #1;
        end
        if (!ok) timeout_fail("bit40_wait");
        chk("pre_rst_bclk", AUD_BCLK, 1);
        chk("pre_rst_dat", AUD_DACDAT, 1);
        reset = 1'b1;
        #1;
        chk("async_rst_bclk", AUD_BCLK, 0);
        chk("async_rst_lrck", AUD_DACLRCK, 1);
        chk("async_rst_dat", AUD_DACDAT, 0);
        chk("async_rst_level", aud.fifo_level, 0);
        repeat (2) @(negedge CLOCK_50);
        release_check_fe();
        drive(1'b1, 1'b0, 32'hC0DE_1234, 32'h4321_EDC0);
        @(negedge CLOCK_50); #1;
        drive(1'b0, 1'b0, '0, '0);
        repeat (2 * FRAME) @(negedge CLOCK_50);

        #1 $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/audio_dac_serializer.md
Name: audio_dac_serializer

Overview:
- DAC-side responder for the audio-out sample interface: it accepts left/right sample pairs from a producer via an allowed/write handshake and buffers them in a small FIFO.
- It generates the codec bit clock and the DAC left/right clock in master mode, and serializes the samples onto AUD_DACDAT in I2S format.
- It sits between user sample logic (tone generators, loopback mixers) and the codec DAC pins.

Parameters:
- DATA_WIDTH, 32, bits per channel sample and per LRCK half-frame (slot = DATA_WIDTH BCLKs).
- FIFO_DEPTH, 4, sample-pair entries; power of 2, at least 2.
- BCLK_HALF, 8, CLOCK_50 cycles per BCLK half-period, at least 2. Default gives a 3.125 MHz BCLK and about 48.8 kHz frames.

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  asynchronous, active-high
- clear_audio_out_memory  in  1  synchronous FIFO flush
- left_channel_audio_out  in  DATA_WIDTH  left sample, two's complement
- right_channel_audio_out  in  DATA_WIDTH  right sample
- write_audio_out  in  1  push request
- audio_out_allowed  out  1  FIFO not full
- fifo_level  out  clog2(FIFO_DEPTH)+1  entries held
- underflow  out  1  one-cycle pulse: frame started with empty FIFO
- AUD_BCLK  out  1  codec bit clock
- AUD_DACLRCK  out  1  0 = left slot, 1 = right slot
- AUD_DACDAT  out  1  serial data

Behaviour:
- Reset values (async, on assertion): all FIFO pointers 0, fifo_level 0, audio_out_allowed 1, underflow 0, AUD_BCLK 0, AUD_DACLRCK 1, AUD_DACDAT 0, div_cnt 0, bit_cnt 2*DATA_WIDTH-1, left/right holding words 0, last_bit 0.
- Handshake:
  - A push occurs when write_audio_out & audio_out_allowed.
  - The pair is written at the cycle edge and is visible in fifo_level the next cycle.
  - A write while full is ignored; no error flag.
  - audio_out_allowed = (fifo_level != FIFO_DEPTH), registered-equivalent.
  - Simultaneous push and pop: level unchanged, both occur.
- Flush: clear_audio_out_memory empties the FIFO next cycle and overrides a same-cycle push. The serializer state and holding words are untouched.
- BCLK:
  - div_cnt counts 0..BCLK_HALF-1; at BCLK_HALF-1 it wraps and AUD_BCLK toggles.
  - A falling-edge event (FE) is a cycle where the toggle takes AUD_BCLK 1 to 0. The first FE occurs 2*BCLK_HALF cycles after reset release.
  - All of AUD_DACLRCK, AUD_DACDAT, and pops update only on FE, in the same edge as BCLK falls.
- Frame counter: on each FE, bit_cnt increments mod 2*DATA_WIDTH. Let n be the new value, i = n mod DATA_WIDTH, ch = n / DATA_WIDTH.
- LRCK: AUD_DACLRCK = ch.
- Pop at n = 0:
  - If the FIFO is non-empty, pop the head into the left/right holding words.
  - If it is empty, load zeros and pulse underflow for exactly one CLOCK_50 cycle.
  - The pop happens in the same cycle as the FE.
- Data (I2S, one-BCLK delay):
  - When i = 0, AUD_DACDAT = last_bit, which is bit 0 of the previous slot's word.
  - When i in 1..DATA_WIDTH-1, AUD_DACDAT = word_ch[DATA_WIDTH-i], so the MSB is sent at i = 1.
  - At n = DATA_WIDTH, last_bit is left word bit 0. At n = 0, last_bit is the previous right word bit 0, captured before the pop overwrites it.
- Continuity: the serial stream never stalls; there are no handshakes to the codec.
- Reset mid-frame: all outputs immediately take their reset values; the frame restarts cleanly after release.

Test Plan:
1. Reset release, no writes → first FE at cycle 16; AUD_DACLRCK falls to 0 at that FE; underflow pulses one cycle; AUD_DACDAT stays 0 for whole frames; BCLK period 16 cycles.
2. Push L=32'h8000_0001, R=32'h7FFF_FFFE before frame 0 → left slot bits i=1..31 read 1,0…0; right slot i=1 reads 0, then ones; bit0 of L (1) appears at i=0 of the right slot; bit0 of R (0) appears at n=0 of the next frame.
3. Hold write_audio_out high from reset → 4 pushes accepted; audio_out_allowed drops with fifo_level=4; after each frame-start pop, allowed rises for one cycle and one more push is accepted.
4. FIFO at 1 entry; push and frame-start pop in same cycle → fifo_level stays 1; no underflow.
5. FIFO at 3 entries; assert clear_audio_out_memory together with write → fifo_level=0 next cycle; the current frame completes with held words; the next frame-start pulses underflow.
6. Assert reset at bit_cnt=40 → AUD_BCLK=0, AUD_DACLRCK=1, AUD_DACDAT=0, fifo_level=0 immediately (async); after release, first FE again at cycle 16.
